vmul_limb_accumulate: RTL and testbench

Multi-pass multiplier stage in the vALU, directly downstream of the operand selector. It consumes the 18-bit pre-extended operand limbs and multiplies them with four 18x18 signed multipliers. Partial products are accumulated over 1, 2 or 4 passes, depending on SEW. The block returns one 64-bit vector of element products, either the low or high SEW half of each, through a valid/ready handshake.

---
 rtl/vmul_pkg.sv | 27 ++
 rtl/limb_mul.sv | 21 ++
 rtl/vmul_limb_accumulate.sv | 228 ++++++++++++++++++++++
 tb/tb_vmul_limb_accumulate.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vmul_pkg.sv
// rtl/vmul_pkg.sv - SEW encodings, FSM state type and pass-count helper for the limb multiplier
package vmul_pkg;

    localparam logic [1:0] SEW_8  = 2'b00;
    localparam logic [1:0] SEW_16 = 2'b01;
    localparam logic [1:0] SEW_32 = 2'b10;
    localparam logic [1:0] SEW_64 = 2'b11;

    // Each limb carries 16 data bits; neighbouring limbs are 16 bits apart in weight.
    localparam int LIMB_SHIFT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Number of accumulation passes an operation needs at a given element width.
    function automatic logic [2:0] num_passes(input logic [1:0] sew_v);
        case (sew_v)
            SEW_32:  num_passes = 3'd2;
            SEW_64:  num_passes = 3'd4;
            default: num_passes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/limb_mul.sv
// rtl/limb_mul.sv - 18x18 signed multiplier with a split mode giving two 9x9 signed byte products
module limb_mul (
    input  logic [17:0] a_i,
    input  logic [17:0] b_i,
    input  logic        byte_mode_i,
    output logic [35:0] p_o
);

    logic signed [35:0] full_prod;
    logic signed [17:0] lo_prod;
    logic signed [17:0] hi_prod;

    // Operands are sign-extended to the product width before multiplying.
    assign full_prod = 36'($signed(a_i)) * 36'($signed(b_i));
    assign lo_prod   = 18'($signed(a_i[8:0])) * 18'($signed(b_i[8:0]));
    assign hi_prod   = 18'($signed(a_i[17:9])) * 18'($signed(b_i[17:9]));

    // Byte mode packs the high-field product above the low-field product.
    assign p_o = byte_mode_i ? {hi_prod, lo_prod} : full_prod;

endmodule

// File: rtl/vmul_limb_accumulate.sv
// rtl/vmul_limb_accumulate.sv - multi-pass limb multiplier with 128-bit accumulator and packed result
module vmul_limb_accumulate
    import vmul_pkg::*;
#(
    parameter int OPERAND_WIDTH = 18,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               sew,
    input  logic                     high,
    input  logic [OPERAND_WIDTH-1:0] m3_a1,
    input  logic [OPERAND_WIDTH-1:0] m3_a0,
    input  logic [OPERAND_WIDTH-1:0] m0_a1,
    input  logic [OPERAND_WIDTH-1:0] m0_a0,
    input  logic [OPERAND_WIDTH-1:0] m3_b1,
    input  logic [OPERAND_WIDTH-1:0] m3_b0,
    input  logic [OPERAND_WIDTH-1:0] m2_b1,
    input  logic [OPERAND_WIDTH-1:0] m2_b0,
    input  logic [OPERAND_WIDTH-1:0] m0_b1,
    input  logic [OPERAND_WIDTH-1:0] m0_b0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    result
);

    state_e                   state_q, state_d;
    logic [1:0]               pass_q, pass_d;
    logic [1:0]               sew_q;
    logic                     high_q;
    logic [OPERAND_WIDTH-1:0] a_q [4];
    logic [OPERAND_WIDTH-1:0] b_q [4];
    logic [OPERAND_WIDTH-1:0] bx_q [2];
    logic [127:0]             acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    result_q, res_d;

    logic [17:0]  mul_a [4];
    logic [17:0]  mul_b [4];
    logic [35:0]  mul_p [4];
    logic [17:0]  w_al, w_ah, w_bl, w_bh;
    logic [63:0]  word_sum;
    logic [127:0] dbl_sum;
    logic         accept;
    logic         last_pass;

    function automatic logic [63:0] sx64(input logic [35:0] p);
        return {{28{p[35]}}, p};
    endfunction

    function automatic logic [127:0] sx128(input logic [35:0] p);
        return {{92{p[35]}}, p};
    endfunction

    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign last_pass = ({1'b0, pass_q} == (num_passes(sew_q) - 3'd1));
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

    // Route latched limbs to the four multipliers according to element width and pass.
    always_comb begin
        w_al = '0;
        w_ah = '0;
        w_bl = '0;
        w_bh = '0;
        for (int i = 0; i < 4; i++) begin
            mul_a[i] = a_q[i];
            mul_b[i] = b_q[i];
        end
        case (sew_q)
            SEW_8: begin
                mul_b[2] = bx_q[0];
                mul_b[3] = bx_q[1];
            end
            SEW_32: begin
                if (pass_q[0]) begin
                    w_al = a_q[2]; w_ah = a_q[3]; w_bl = b_q[2]; w_bh = b_q[3];
                end else begin
                    w_al = a_q[0]; w_ah = a_q[1]; w_bl = b_q[0]; w_bh = b_q[1];
                end
                mul_a[0] = w_al; mul_b[0] = w_bl;
                mul_a[1] = w_ah; mul_b[1] = w_bl;
                mul_a[2] = w_al; mul_b[2] = w_bh;
                mul_a[3] = w_ah; mul_b[3] = w_bh;
            end
            SEW_64: begin
                for (int i = 0; i < 4; i++) begin
                    mul_a[i] = a_q[pass_q];
                end
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_mul
        limb_mul u_limb_mul (
            .a_i         (mul_a[g]),
            .b_i         (mul_b[g]),
            .byte_mode_i (sew_q == SEW_8),
            .p_o         (mul_p[g])
        );
    end

    // Shift/add tree: fold this pass's partial products into the accumulator.
    always_comb begin
        word_sum = sx64(mul_p[0])
                 + (sx64(mul_p[1]) << LIMB_SHIFT)
                 + (sx64(mul_p[2]) << LIMB_SHIFT)
                 + (sx64(mul_p[3]) << (2 * LIMB_SHIFT));
        dbl_sum = acc_q;
        for (int j = 0; j < 4; j++) begin
            dbl_sum = dbl_sum + (sx128(mul_p[j]) << 7'(LIMB_SHIFT * (int'(pass_q) + j)));
        end
        acc_d = acc_q;
        case (sew_q)
            SEW_8: begin
                for (int i = 0; i < 4; i++) begin
                    acc_d[32*i +: 16]    = mul_p[i][15:0];
                    acc_d[32*i+16 +: 16] = mul_p[i][33:18];
                end
            end
            SEW_16: begin
                for (int i = 0; i < 4; i++) begin
                    acc_d[32*i +: 32] = mul_p[i][31:0];
                end
            end
            SEW_32: begin
                if (pass_q[0]) acc_d[127:64] = word_sum;
                else           acc_d[63:0]   = word_sum;
            end
            default: acc_d = dbl_sum;
        endcase
    end

    // Pick the low or high SEW half of each 2*SEW product slot into the packed result.
    always_comb begin
        res_d = '0;
        case (sew_q)
            SEW_8: begin
                for (int e = 0; e < 8; e++) begin
                    res_d[8*e +: 8] = high_q ? acc_d[16*e+8 +: 8] : acc_d[16*e +: 8];
                end
            end
            SEW_16: begin
                for (int e = 0; e < 4; e++) begin
                    res_d[16*e +: 16] = high_q ? acc_d[32*e+16 +: 16] : acc_d[32*e +: 16];
                end
            end
            SEW_32: begin
                for (int e = 0; e < 2; e++) begin
                    res_d[32*e +: 32] = high_q ? acc_d[64*e+32 +: 32] : acc_d[64*e +: 32];
                end
            end
            default: res_d = high_q ? acc_d[127:64] : acc_d[63:0];
        endcase
    end

    // Next-state and pass-counter logic.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_BUSY;
                    pass_d  = 2'd0;
                end
            end
            ST_BUSY: begin
                if (last_pass) begin
                    state_d = ST_DONE;
                    pass_d  = 2'd0;
                end else begin
                    pass_d = pass_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pass registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pass_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    // Capture operands and mode on accept; they stay put for the whole operation.
    always_ff @(posedge clk) begin
        if (accept) begin
            sew_q   <= sew;
            high_q  <= high;
            a_q[0]  <= m3_a1;
            a_q[1]  <= m3_a0;
            a_q[2]  <= m0_a1;
            a_q[3]  <= m0_a0;
            b_q[0]  <= m3_b1;
            b_q[1]  <= m3_b0;
            b_q[2]  <= m2_b1;
            b_q[3]  <= m2_b0;
            bx_q[0] <= m0_b1;
            bx_q[1] <= m0_b0;
        end
    end

    // Accumulator and output register; the result is captured on the final pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
        end else if (state_q == ST_BUSY) begin
            acc_q <= acc_d;
            if (last_pass) result_q <= res_d;
        end
    end

endmodule

// File: tb/tb_vmul_limb_accumulate.sv
// tb/tb_vmul_limb_accumulate.sv - table-driven bench for vmul_limb_accumulate
module tb_vmul_limb_accumulate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  sew = 2'b00;
    logic        high = 1'b0;
    logic [17:0] m3_a1 = '0, m3_a0 = '0, m0_a1 = '0, m0_a0 = '0;
    logic [17:0] m3_b1 = '0, m3_b0 = '0, m2_b1 = '0, m2_b0 = '0;
    logic [17:0] m0_b1 = '0, m0_b0 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    always #5 clk = ~clk;

    vmul_limb_accumulate #(.OPERAND_WIDTH(18), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sew(sew), .high(high),
        .m3_a1(m3_a1), .m3_a0(m3_a0), .m0_a1(m0_a1), .m0_a0(m0_a0),
        .m3_b1(m3_b1), .m3_b0(m3_b0), .m2_b1(m2_b1), .m2_b0(m2_b0),
        .m0_b1(m0_b1), .m0_b0(m0_b0),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    typedef struct {
        logic [1:0]       sew;
        logic             high;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        logic [1:0][17:0] bx;
        logic [63:0]      exp;
        int               lat;
    } vec_t;

    vec_t vecs[14];
    int   checks = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sew   = v.sew;   high  = v.high;
        m3_a1 = v.a[0];  m3_a0 = v.a[1];  m0_a1 = v.a[2];  m0_a0 = v.a[3];
        m3_b1 = v.b[0];  m3_b0 = v.b[1];  m2_b1 = v.b[2];  m2_b0 = v.b[3];
        m0_b1 = v.bx[0]; m0_b0 = v.bx[1];
    endtask

    task automatic run_op(input vec_t v, output logic [63:0] res, output int lat);
        drive(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        res = result;
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        int          lat;
        logic        seen;

        vecs[0]  = '{sew:2'b01, high:1'b0,
                     a:{18'h08000, 18'h3FFFF, 18'h00007, 18'h3FFFD},
                     b:{18'h08000, 18'h3FFFF, 18'h00003, 18'h00005},
                     bx:36'h0, exp:64'h0000_0001_0015_FFF1, lat:1};
        vecs[1]  = vecs[0];
        vecs[1].high = 1'b1; vecs[1].exp = 64'h4000_0000_0000_FFFF;
        vecs[2]  = '{sew:2'b00, high:1'b0,
                     a:{4{18'h30180}},
                     b:{18'h12345, 18'h12345, 18'h30180, 18'h30180},
                     bx:{2{18'h30180}}, exp:64'h0, lat:1};
        vecs[3]  = vecs[2];
        vecs[3].high = 1'b1; vecs[3].exp = 64'h4040_4040_4040_4040;
        vecs[4]  = '{sew:2'b00, high:1'b0,
                     a:{18'h3FEFF, 18'h0, 18'h0, 18'h3FC03},
                     b:{18'h3FFFF, 18'h3FFFF, 18'h0, 18'h00E05},
                     bx:{18'h100FF, 18'h0}, exp:64'h8001_0000_0000_F20F, lat:1};
        vecs[5]  = vecs[4];
        vecs[5].high = 1'b1; vecs[5].exp = 64'hFFFE_0000_0000_FF00;
        vecs[6]  = '{sew:2'b10, high:1'b0,
                     a:{18'h0, 18'h0, 18'h3FFFF, 18'h0FFFF},
                     b:{18'h0, 18'h0, 18'h0, 18'h00002},
                     bx:36'h0, exp:64'h0000_0000_FFFF_FFFE, lat:2};
        vecs[7]  = vecs[6];
        vecs[7].high = 1'b1; vecs[7].exp = 64'h0000_0000_FFFF_FFFF;
        vecs[8]  = '{sew:2'b10, high:1'b0,
                     a:{18'h0, 18'h00003, 18'h0FFFF, 18'h0FFFF},
                     b:{18'h3FFFF, 18'h0FFFF, 18'h0, 18'h00002},
                     bx:36'h0, exp:64'hFFFF_FFFD_FFFF_FFFE, lat:2};
        vecs[9]  = vecs[8];
        vecs[9].high = 1'b1; vecs[9].exp = 64'hFFFF_FFFF_0000_0001;
        vecs[10] = '{sew:2'b11, high:1'b0,
                     a:{18'h38000, 18'h0, 18'h0, 18'h0},
                     b:{18'h3FFFF, 18'h0FFFF, 18'h0FFFF, 18'h0FFFF},
                     bx:36'h0, exp:64'h8000_0000_0000_0000, lat:4};
        vecs[11] = vecs[10];
        vecs[11].high = 1'b1; vecs[11].exp = 64'h0;
        vecs[12] = '{sew:2'b11, high:1'b1,
                     a:{18'h0, 18'h0, 18'h0, 18'h00003},
                     b:{18'h0FFFF, 18'h0FFFF, 18'h0FFFF, 18'h0FFFF},
                     bx:36'h0, exp:64'h0000_0000_0000_0002, lat:4};
        vecs[13] = '{sew:2'b11, high:1'b0,
                     a:{18'h3FFFF, 18'h0FFFF, 18'h0FFFF, 18'h0FFFF},
                     b:{18'h3FFFF, 18'h0FFFF, 18'h0FFFF, 18'h0FFFF},
                     bx:36'h0, exp:64'h0000_0000_0000_0001, lat:4};

        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_result", result, 64'h0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            transfer();
        end

        run_op(vecs[8], res, lat);
        chk("bp_first_result", res, vecs[8].exp);
        held = res;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                drive(vecs[0]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            chk($sformatf("bp_hold%0d_result", k), result, held);
            chk($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'h1);
            chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'h0);
        end
        in_valid = 1'b0;
        transfer();
        chk("bp_after_in_ready", 64'(in_ready), 64'h1);
        chk("bp_after_out_valid", 64'(out_valid), 64'h0);
        run_op(vecs[0], res, lat);
        chk("b2b_result", res, vecs[0].exp);
        chk("b2b_latency", 64'(lat), 64'd1);
        transfer();

        drive(vecs[6]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'h1);
        chk("rst_mid_out_valid", 64'(out_valid), 64'h0);
        chk("rst_mid_result", result, 64'h0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("rst_mid_no_out_valid", 64'(seen), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
